// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        rd_sel;
  logic        busy;
  logic        md_stall;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, A, B, rd_sel,
    input  busy, md_stall, md_out, hi, lo
  );

  modport slave (
    input  start, op, A, B, rd_sel,
    output busy, md_stall, md_out, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// HI/LO owner for the E stage: fixed-latency mult/multu/div/divu, single-cycle mthi/mtlo,
// and the busy/stall indication used by the hazard logic.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       hi_n_q, hi_n_d;
  logic [31:0]       lo_n_q, lo_n_d;
  logic              wr_n_q, wr_n_d;

  logic              is_iter;
  logic [63:0]       prod_s;
  logic [63:0]       prod_u;
  logic [31:0]       divisor;
  logic [31:0]       abs_a;
  logic [31:0]       abs_b;
  logic [31:0]       sq_mag;
  logic [31:0]       sr_mag;
  logic [31:0]       s_quo;
  logic [31:0]       s_rem;
  logic [31:0]       u_quo;
  logic [31:0]       u_rem;

  assign is_iter = (md.op >= OP_MULT) && (md.op <= OP_DIVU);

  // Result is formed from the start-cycle operands and parked until the counter expires.
  // Signed division goes through magnitudes so the 0x80000000 / -1 case wraps naturally.
  always_comb begin
    prod_s  = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    prod_u  = {32'd0, md.A} * {32'd0, md.B};
    divisor = (md.B == '0) ? 32'd1 : md.B;
    abs_a   = md.A[31] ? (32'd0 - md.A) : md.A;
    abs_b   = divisor[31] ? (32'd0 - divisor) : divisor;
    sq_mag  = abs_a / abs_b;
    sr_mag  = abs_a % abs_b;
    s_quo   = (md.A[31] ^ divisor[31]) ? (32'd0 - sq_mag) : sq_mag;
    s_rem   = md.A[31] ? (32'd0 - sr_mag) : sr_mag;
    u_quo   = md.A / divisor;
    u_rem   = md.A % divisor;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    wr_n_d  = wr_n_q;
    unique case (state_q)
      IDLE: begin
        if (md.start) begin
          if (is_iter) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
          case (md.op)
            OP_MULT: begin
              {hi_n_d, lo_n_d} = prod_s;
              wr_n_d = 1'b1;
              cnt_d  = CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
              {hi_n_d, lo_n_d} = prod_u;
              wr_n_d = 1'b1;
              cnt_d  = CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
              hi_n_d = s_rem;
              lo_n_d = s_quo;
              wr_n_d = (md.B != '0);
              cnt_d  = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
              hi_n_d = u_rem;
              lo_n_d = u_quo;
              wr_n_d = (md.B != '0);
              cnt_d  = CNT_W'(DIV_CYCLES);
            end
            OP_MTHI: hi_d = md.A;
            OP_MTLO: lo_d = md.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (wr_n_q) begin
            hi_d = hi_n_q;
            lo_d = lo_n_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
      wr_n_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      wr_n_q  <= wr_n_d;
    end
  end

  assign md.busy     = busy_q;
  assign md.md_stall = busy_q | (md.start & is_iter);
  assign md.md_out   = md.rd_sel ? hi_q : lo_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected HI/LO and busy length,
// a negedge monitor retires an entry each time busy falls.
module tb_mult_div_unit;

  logic clk;
  logic reset;

  mult_div_unit_if mif();

  mult_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned len;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned busy_len = 0;
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: busy falling is the completion event.
  always @(negedge clk) begin
    if (mif.busy === 1'b1) begin
      busy_len++;
    end else if (prev_busy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: completion seen with no expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, mif.hi, e.hi);
        check({e.name, "_lo"}, mif.lo, e.lo);
        check({e.name, "_len"}, busy_len, e.len);
      end
      busy_len = 0;
    end
    prev_busy = mif.busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start pulse; checks md_stall in the start cycle.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic stall_exp, input string name);
    mif.start = 1'b1;
    mif.op    = op;
    mif.A     = a;
    mif.B     = b;
    #1;
    check({name, "_stall_start"}, {31'd0, mif.md_stall}, {31'd0, stall_exp});
    tick();
    mif.start = 1'b0;
    mif.op    = 3'd0;
    mif.A     = $urandom;
    mif.B     = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int unsigned guard = 0;
    while (mif.busy === 1'b1 && guard < 50) begin
      check({name, "_stall_busy"}, {31'd0, mif.md_stall}, 32'd1);
      tick();
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: busy still high after %0d cycles", name, guard);
    end
    check({name, "_stall_done"}, {31'd0, mif.md_stall}, 32'd0);
    tick();
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int unsigned elen, input string name);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.len = elen; e.name = name;
    sb.push_back(e);
    start_op(op, a, b, 1'b1, name);
    wait_idle(name);
  endtask

  initial begin
    exp_t e;
    reset      = 1'b1;
    mif.start  = 1'b0;
    mif.op     = 3'd0;
    mif.A      = '0;
    mif.B      = '0;
    mif.rd_sel = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_busy", {31'd0, mif.busy}, 32'd0);
    check("rst_stall", {31'd0, mif.md_stall}, 32'd0);
    check("rst_hi", mif.hi, 32'd0);
    check("rst_lo", mif.lo, 32'd0);
    check("rst_md_out", mif.md_out, 32'd0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, "mult_neg");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, "multu");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg");
    run_op(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, "div_ovf");
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, "div_pos_neg");

    start_op(3'd5, 32'h1234_5678, 32'd0, 1'b0, "mthi");
    check("mthi_hi", mif.hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, mif.busy}, 32'd0);
    start_op(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, "mtlo");
    check("mtlo_lo", mif.lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", mif.hi, 32'h1234_5678);

    run_op(3'd4, 32'd5, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10, "divu_by0");
    mif.rd_sel = 1'b1;
    #1;
    check("md_out_hi", mif.md_out, 32'h1234_5678);
    mif.rd_sel = 1'b0;
    #1;
    check("md_out_lo", mif.md_out, 32'h9ABC_DEF0);

    start_op(3'd0, 32'hAAAA_AAAA, 32'd1, 1'b0, "nop0");
    start_op(3'd7, 32'hBBBB_BBBB, 32'd1, 1'b0, "nop7");
    check("nop_hi", mif.hi, 32'h1234_5678);
    check("nop_lo", mif.lo, 32'h9ABC_DEF0);
    check("nop_busy", {31'd0, mif.busy}, 32'd0);

    // Starts during RUN must be ignored.
    e.hi = 32'd0; e.lo = 32'd12; e.len = 5; e.name = "mult_ign";
    sb.push_back(e);
    start_op(3'd1, 32'd3, 32'd4, 1'b1, "mult_ign");
    start_op(3'd5, 32'h0000_DEAD, 32'd0, 1'b1, "ign_mthi");
    check("ign_hi_kept", mif.hi, 32'h1234_5678);
    start_op(3'd3, 32'd100, 32'd3, 1'b1, "ign_div");
    wait_idle("mult_ign");
    check("ign_after_busy", {31'd0, mif.busy}, 32'd0);

    // Reset during busy cycle 3 of a divide discards it.
    e.hi = 32'd0; e.lo = 32'd0; e.len = 3; e.name = "div_rst";
    sb.push_back(e);
    start_op(3'd3, 32'd100, 32'd7, 1'b1, "div_rst");
    tick();
    tick();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, mif.busy}, 32'd0);
    check("rst_mid_hi", mif.hi, 32'd0);
    check("rst_mid_lo", mif.lo, 32'd0);
    check("rst_mid_md_out", mif.md_out, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_op(3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 5, "mult_post_rst");

    tick();
    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d pending entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit for the E stage of the pipelined CPU: it owns the HI/LO register pair, executes mult/multu/div/divu with fixed iteration latency and mthi/mtlo in one cycle, and supplies HI or LO to the write-back data select path for mfhi/mflo. It also presents the busy/stall indication the hazard logic uses to hold later mult/div/mf/mt instructions in D.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  qualifies op; one-cycle pulse per instruction
- op  input  3  3'd1 mult, 3'd2 multu, 3'd3 div, 3'd4 divu, 3'd5 mthi, 3'd6 mtlo; 0 and 7 are no-op
- A  input  32  rs operand (dividend / multiplicand / mt source)
- B  input  32  rt operand (divisor / multiplier)
- rd_sel  input  1  0 selects LO, 1 selects HI onto md_out
- busy  output  1  registered; high while an iterative op is in flight
- md_stall  output  1  combinational: busy | (start & op in 1..4)
- md_out  output  32  combinational: rd_sel ? HI : LO
- hi  output  32  current HI register
- lo  output  32  current LO register

## Operation
- States: IDLE, RUN. Down-counter cnt, width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
- IDLE, start & op in 1..4: latch A, B, op; compute 64-bit result into pending hi_n/lo_n (may be computed combinationally at latch time or iteratively — only the visible timing below is binding); cnt <= MULT_CYCLES or DIV_CYCLES; go RUN, busy <= 1.
- RUN: cnt decrements each edge; on the edge where cnt == 1: HI <= hi_n, LO <= lo_n, busy <= 0, go IDLE.
- IDLE, start & op == 5: HI <= A on that edge; op == 6: LO <= A. No busy.
- start during RUN (any op): ignored entirely; latched operands, counter and HI/LO unaffected. The hazard logic guarantees this does not occur; the block still must not corrupt state.
- start with op 0 or 7: no effect.
- Arithmetic:
  - mult: signed 32x32 -> 64, {HI,LO} = product.
  - multu: unsigned 32x32 -> 64.
  - div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend.
  - div overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0x00000000.
  - divu: unsigned quotient/remainder.
  - div/divu with B == 0: busy runs full DIV_CYCLES; HI and LO left unchanged at completion.
- md_out and hi/lo reflect register contents only; there is no bypass of pending results.

## Timing
- Reset (async, any time incl. mid-RUN): state IDLE, busy=0, cnt=0, HI=0, LO=0, so md_out=0; the in-flight op is discarded.
- Start accepted at edge E0 -> busy=1 from E0 through the edge E0+N (N = MULT_CYCLES or DIV_CYCLES); HI/LO new values and busy=0 visible after edge E0+N. Back-to-back start accepted at E0+N+1 at earliest, i.e. the first cycle with busy=0.
- md_stall is high in the start cycle itself and in every busy cycle; low otherwise.
- mthi/mtlo: new value visible on hi/lo/md_out the cycle after the start edge.
- Operands A/B need be valid only in the start cycle.

## Test plan
- Reset, then start op=1 A=0xFFFFFFFF B=2 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; repeat op=2 -> HI=0x00000001 LO=0xFFFFFFFE.
- op=3 A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; op=4 A=7 B=2 -> LO=3 HI=1; op=3 A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000 HI=0.
- mthi A=0x12345678, mtlo A=0x9ABCDEF0 then op=4 B=0 -> after 10 busy cycles HI=0x12345678, LO=0x9ABCDEF0 unchanged; rd_sel toggling shows each on md_out.
- op=1 A=3 B=4 started, then start op=5 A=0xDEAD and op=3 pulses during busy -> ignored; final HI=0 LO=12 at cycle 5.
- Assert reset in busy cycle 3 of a div -> busy, HI, LO, md_out drop to 0 immediately; following start op=1 A=2 B=3 completes normally with LO=6.
- md_stall check: high in start cycle and all busy cycles, low in the cycle busy falls and for mthi/mtlo/no-op starts.
